// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: function codes, FSM states and helpers.
// The optional single-cycle multiplier is enabled by defining MDU_FAST_MUL_EN.
package mdu_pkg;

    localparam int unsigned ITER  = 32;
    localparam int unsigned CNT_W = 6;

    localparam logic [5:0] MTHI  = 6'h11;
    localparam logic [5:0] MTLO  = 6'h13;
    localparam logic [5:0] MULT  = 6'h18;
    localparam logic [5:0] MULTU = 6'h19;
    localparam logic [5:0] DIV   = 6'h1a;
    localparam logic [5:0] DIVU  = 6'h1b;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_MUL  = 2'd1,
        MDU_DIV  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_e;

`ifdef MDU_FAST_MUL_EN
    localparam logic [CNT_W-1:0] MUL_LAST = '0;
`else
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(ITER - 1);
`endif
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(ITER - 1);

    // Two's-complement magnitude; 32'h80000000 maps to itself, which is its unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Unsigned restoring divider core: one quotient bit per step, MSB first, 32 steps.
// Exposes the post-step quotient/remainder so the caller can commit on the final step edge.
module mdu_div_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quo_next,
    output logic [31:0] rem_next,
    output logic        last
);
    import mdu_pkg::*;

    logic [31:0]      quo_q;
    logic [31:0]      rem_q;
    logic [31:0]      dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic [32:0]      partial;
    logic [32:0]      diff;

    // A zero divisor never borrows, so it naturally yields quotient all-ones, remainder = dividend.
    assign partial  = {rem_q, quo_q[31]};
    assign diff     = partial - {1'b0, dvs_q};
    assign rem_next = diff[32] ? partial[31:0] : diff[31:0];
    assign quo_next = {quo_q[30:0], ~diff[32]};
    assign last     = step && (cnt_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
            cnt_q <= '0;
        end else if (step) begin
            quo_q <= quo_next;
            rem_q <= rem_next;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO; iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
// Define MDU_FAST_MUL_EN for a single-cycle multiply; divide stays iterative.
module mdu (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  func,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    import mdu_pkg::*;

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [63:0]      prod_q;
    logic [31:0]      mcand_q;
    logic             neg_q;
    logic             rsign_q;
    logic             dvz_q;

    logic        accept;
    logic        is_mul;
    logic        is_div;
    logic        is_signed;
    logic [31:0] a_op;
    logic [31:0] b_op;
    logic        mul_last;
    logic        div_last;
    logic [63:0] prod_next;
    logic [63:0] prod_fix;
    logic [31:0] quo_next;
    logic [31:0] rem_next;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign accept    = start && !flush && (state_q == MDU_IDLE || state_q == MDU_DONE);
    assign is_mul    = (func == MULT) || (func == MULTU);
    assign is_div    = (func == DIV) || (func == DIVU);
    assign is_signed = (func == MULT) || (func == DIV);
    assign a_op      = is_signed ? mag32(A) : A;
    assign b_op      = is_signed ? mag32(B) : B;
    assign mul_last  = (cnt_q == MUL_LAST);

`ifdef MDU_FAST_MUL_EN
    // Full product of the latched magnitudes in a single MUL cycle.
    assign prod_next = {32'b0, mcand_q} * {32'b0, prod_q[31:0]};
`else
    logic [32:0] mul_sum;

    // Multiplier sits in the low half and shifts out as the partial product shifts in.
    assign mul_sum   = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
    assign prod_next = {mul_sum, prod_q[31:1]};
`endif

    assign prod_fix = neg_q ? (~prod_next + 64'd1) : prod_next;
    assign quo_fix  = dvz_q ? 32'hffff_ffff : (neg_q ? (~quo_next + 32'd1) : quo_next);
    // On divide-by-zero the remainder magnitude is |A|, so the dividend-sign fix-up restores A.
    assign rem_fix  = rsign_q ? (~rem_next + 32'd1) : rem_next;

    mdu_div_iter u_div_iter (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .load     (accept && is_div),
        .step     (state_q == MDU_DIV),
        .dividend (a_op),
        .divisor  (b_op),
        .quo_next (quo_next),
        .rem_next (rem_next),
        .last     (div_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            rsign_q <= 1'b0;
            dvz_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else if (flush) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                MDU_IDLE, MDU_DONE: begin
                    state_q <= MDU_IDLE;
                    if (accept) begin
                        if (func == MTHI) hi <= A;
                        if (func == MTLO) lo <= A;
                        if (is_mul || is_div) begin
                            busy    <= 1'b1;
                            cnt_q   <= '0;
                            neg_q   <= is_signed && (A[31] ^ B[31]);
                            state_q <= is_mul ? MDU_MUL : MDU_DIV;
                        end
                        if (is_mul) begin
                            mcand_q <= a_op;
                            prod_q  <= {32'b0, b_op};
                        end
                        if (is_div) begin
                            rsign_q <= is_signed && A[31];
                            dvz_q   <= (B == '0);
                        end
                    end
                end
                MDU_MUL: begin
                    prod_q <= prod_next;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (mul_last) begin
                        {hi, lo} <= prod_fix;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state_q  <= MDU_DONE;
                    end
                end
                MDU_DIV: begin
                    if (div_last) begin
                        hi      <= rem_fix;
                        lo      <= quo_fix;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= MDU_DONE;
                    end
                end
                default: state_q <= MDU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: latency, results, corner divides, flush and reset.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    int seen;

`ifdef MDU_FAST_MUL_EN
    localparam int MulLat = 1;
`else
    localparam int MulLat = 32;
`endif
    localparam int DivLat = 32;

    mdu dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .func  (func),
        .A     (a),
        .B     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive a request for one edge; returns at the negedge of cycle T+1.
    task automatic issue(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        func  = f;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts remaining busy cycles (bounded) and checks the completion cycle.
    task automatic finish_op(input string tag, input int lat, input logic [31:0] eh,
                             input logic [31:0] el);
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".lat"}, n, lat);
        check({tag, ".done"}, done, 1);
        check({tag, ".hi"}, hi, eh);
        check({tag, ".lo"}, lo, el);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        func  = '0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("rst.hi", hi, 0);
        check("rst.lo", lo, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        reset = 1'b0;
        @(negedge clk);

        issue(MULT, 32'hffff_fffe, 32'd3);
        check("mult.busy", busy, 1);
        finish_op("mult", MulLat, 32'hffff_ffff, 32'hffff_fffa);
        @(negedge clk);
        check("mult.pulse", done, 0);
        issue(MULTU, 32'hffff_fffe, 32'd3);
        finish_op("multu", MulLat, 32'h0000_0002, 32'hffff_fffa);
        @(negedge clk);
        issue(MULT, 32'd7, 32'hffff_fffd);
        finish_op("mult_neg", MulLat, 32'hffff_ffff, 32'hffff_ffeb);
        @(negedge clk);
        issue(MULT, 32'h8000_0000, 32'h8000_0000);
        finish_op("mult_min", MulLat, 32'h4000_0000, 32'h0000_0000);
        @(negedge clk);

        issue(DIV, 32'hffff_fff9, 32'd2);
        check("div.busy", busy, 1);
        finish_op("div", DivLat, 32'hffff_ffff, 32'hffff_fffd);
        @(negedge clk);
        check("div.pulse", done, 0);
        issue(DIVU, 32'd7, 32'd2);
        finish_op("divu", DivLat, 32'd1, 32'd3);
        @(negedge clk);
        issue(DIV, 32'h8000_0000, 32'hffff_ffff);
        finish_op("div_ovf", DivLat, 32'h0, 32'h8000_0000);
        @(negedge clk);
        issue(DIVU, 32'd5, 32'd0);
        finish_op("divu_z", DivLat, 32'd5, 32'hffff_ffff);
        @(negedge clk);
        issue(DIV, 32'hffff_fffb, 32'd0);
        finish_op("div_z", DivLat, 32'hffff_fffb, 32'hffff_ffff);
        @(negedge clk);

        issue(MTHI, 32'h1234_5678, 32'd0);
        check("mthi.hi", hi, 32'h1234_5678);
        check("mthi.busy", busy, 0);
        check("mthi.done", done, 0);
        issue(MTLO, 32'ha5a5_a5a5, 32'd0);
        check("mtlo.lo", lo, 32'ha5a5_a5a5);
        check("mtlo.hi", hi, 32'h1234_5678);

        // MTLO issued while a divide is in flight must be dropped.
        issue(DIVU, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        issue(MTLO, 32'hdead_beef, 32'd0);
        check("mtlo_busy.lo", lo, 32'ha5a5_a5a5);
        check("mtlo_busy.busy", busy, 1);
        finish_op("mtlo_busy", DivLat - 4, 32'd2, 32'd14);
        @(negedge clk);

        // Flush at cycle T+10 of a divide.
        issue(DIV, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush.busy", busy, 0);
        check("flush.done", done, 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check("flush.quiet", seen, 0);
        check("flush.hi", hi, 32'd2);
        check("flush.lo", lo, 32'd14);

        // Flush coincident with start drops the request.
        flush = 1'b1;
        issue(MTHI, 32'hffff_0000, 32'd0);
        flush = 1'b0;
        check("flush_st.hi", hi, 32'd2);
        flush = 1'b1;
        issue(MULT, 32'd3, 32'd3);
        flush = 1'b0;
        check("flush_st.busy", busy, 0);
        @(negedge clk);
        check("flush_st.busy2", busy, 0);
        check("flush_st.lo", lo, 32'd14);

        // A new request issued in the DONE cycle is accepted.
        issue(MULTU, 32'd3, 32'd5);
        finish_op("pre_done", MulLat, 32'd0, 32'd15);
        issue(DIVU, 32'd9, 32'd4);
        check("done_start.busy", busy, 1);
        finish_op("done_start", DivLat, 32'd1, 32'd2);
        @(negedge clk);

        // Reset in the middle of a multiply.
        issue(MULT, 32'd5, 32'd6);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid.hi", hi, 0);
        check("rst_mid.lo", lo, 0);
        check("rst_mid.busy", busy, 0);
        check("rst_mid.done", done, 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check("rst_mid.quiet", seen, 0);
        check("rst_mid.lo2", lo, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit; owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU iteratively, and performs MTHI/MTLO writes.
- Exports HI/LO to the EX stage for MFHI/MFLO.
- Sits beside the ALU in EX. The pipeline stalls on `busy` and cancels in-flight work with `flush` on exception/ERET.

Parameters:
- ITER, 32: iteration count for the shift-add multiply and restoring divide. Fixed at 32; it sizes the 6-bit counter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request valid for one cycle; sampled only when not busy
- func  in  6  function code: `MULT`, `MULTU`, `DIV`, `DIVU`, `MTHI`, `MTLO` (head.vh encodings)
- A  in  32  rs operand / dividend / multiplicand / MTHI-MTLO source
- B  in  32  rt operand / divisor / multiplier
- flush  in  1  abort in-flight operation
- busy  out  1  operation in progress; pipeline must stall
- done  out  1  one-cycle completion pulse
- hi  out  32  architectural HI register
- lo  out  32  architectural LO register

Behaviour:
- Reset (reset=1 at an edge):
  - State goes to IDLE.
  - hi=0, lo=0, busy=0, done=0, counter=0.
  - Any operation in progress is dropped.
- States: IDLE, MUL, DIV, DONE. DONE accepts a new start exactly like IDLE.
- Accepting start in IDLE/DONE at cycle T:
  - `MTHI`: hi<=A at end of T. No busy, no done pulse. `MTLO`: same, writing lo.
  - `MULT`/`MULTU` → MUL. `DIV`/`DIVU` → DIV. Other func values are ignored.
- Latching at T:
  - Signed ops latch |A| and |B| plus sign flags. Unsigned ops latch A and B raw.
- Iteration:
  - Cycles T+1..T+32 with busy=1; counter runs 0..31.
  - MUL: 64-bit shift-add on the magnitudes.
  - DIV: restoring division, one quotient bit per cycle, MSB first.
- Final iteration edge (end of T+32):
  - Sign fix-up is applied combinationally, then hi/lo are written.
  - The state machine enters DONE.
- Cycle T+33: done=1, busy=0, hi/lo already show the new values.
- Result placement:
  - MUL: {hi,lo} = 64-bit product, negated if the operand signs differ (signed only).
  - DIV: lo=quotient, hi=remainder.
  - Signed quotient is negated if the signs differ; remainder takes the dividend's sign.
- Divide by zero:
  - Completes with normal latency. No exception is raised.
  - Result is lo=32'hFFFFFFFF, hi=A for both DIV and DIVU; sign fix-up is suppressed.
- DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0. No exception.
- start while busy=1: ignored, including MTHI/MTLO. The pipeline must hold the request.
- flush:
  - Next state is IDLE; busy=0 and done=0 next cycle.
  - hi/lo keep their pre-operation values.
  - flush beats start in the same cycle.
  - flush at the final iteration edge beats the hi/lo write.
- reset beats flush and start.
- No integer-overflow output; these operations never trap.

Optional Feature:
- MDU_FAST_MUL_EN defined:
  - MULT/MULTU compute a 33x33 signed product in one MUL cycle.
  - hi/lo are written at end of T+1; done=1 and busy=0 at T+2.
  - Divide is unchanged.
- Undefined: 32-cycle iterative multiply as above.

Decomposition:
- head.vh gains:
  - `MULT`, `MULTU`, `DIV`, `DIVU` func defines alongside the existing `MTHI`/`MTLO`.
  - `MDU_IDLE`/`MDU_MUL`/`MDU_DIV`/`MDU_DONE` 2-bit state constants.
- One sub-module, `div_iter`:
  - 32-step restoring unsigned divider core (remainder/quotient registers, step enable, counter).
  - mdu keeps the FSM, sign handling, multiplier datapath and HI/LO.

Test Plan:
- MULT A=32'hFFFFFFFE B=3 → busy cycles T+1..T+32; done at T+33; hi=32'hFFFFFFFF, lo=32'hFFFFFFFA. MULTU with the same operands → hi=2, lo=32'hFFFFFFFA.
- DIV A=-7 (32'hFFFFFFF9) B=2 → lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU A=7 B=2 → lo=3, hi=1.
- Corner divides:
  - DIV 32'h80000000 / 32'hFFFFFFFF → lo=32'h80000000, hi=0.
  - DIVU 5/0 → lo=32'hFFFFFFFF, hi=5.
- MTHI A=32'h12345678 → hi updates next cycle, busy and done stay 0. MTLO issued during a busy DIV → ignored, lo keeps its old value.
- Flush paths:
  - flush at cycle T+10 of a DIV → busy=0 next cycle, no done pulse, hi/lo unchanged.
  - flush coincident with a new start → start dropped.
- Reset asserted mid-MUL → hi=lo=0, busy=0. A start issued in the DONE cycle → accepted, busy next cycle. With MDU_FAST_MUL_EN, a MULT completes with done at T+2.
